// File: rtl/rr_arbiter_8_if.sv
// Arbiter bus interface: groups the request side and grant side signals.
//   en        : arbitration enable (requester side -> arbiter)
//   req       : request vector, bit i belongs to requester i
//   gnt       : registered one-hot grant, zero when idle
//   gnt_id    : encoded index of the owner, 0 when idle (drives the bus mux select)
//   gnt_valid : high whenever gnt is nonzero
//   timeout   : one-cycle pulse on a forced revoke
// Modports: master = requesting engines, slave = arbiter.
interface rr_arbiter_8_if #(
  parameter int NREQ = 8,
  parameter int IDW  = 3
);
  logic            en;
  logic [NREQ-1:0] req;
  logic [NREQ-1:0] gnt;
  logic [IDW-1:0]  gnt_id;
  logic            gnt_valid;
  logic            timeout;

  modport master (output en, req, input gnt, gnt_id, gnt_valid, timeout);
  modport slave  (input en, req, output gnt, gnt_id, gnt_valid, timeout);
endinterface

// File: rtl/rr_arbiter_8.sv
// rr_arbiter_8: round-robin arbiter for 8 requesters, MSB-first search order.
// Ports:
//   clk       : system clock, rising edge
//   rst       : synchronous active-high reset
//   bus       : rr_arbiter_8_if.slave (en, req in; gnt, gnt_id, gnt_valid, timeout out)
//   state_dbg : current FSM state (0 = IDLE, 1 = GRANT)
// Handshake: a requester holds req[i] high for as long as it owns the resource;
// ownership is signalled by gnt[i] one cycle after req is sampled, and is kept
// until req[i] is seen low on a rising edge. All outputs come straight from flops.
// Optional macro ARB_TIMEOUT_EN: builds an 8-bit hold counter that forces
// rotation after MAX_HOLD consecutive grant cycles when someone else is waiting.
module rr_arbiter_8 #(
  parameter int NREQ     = 8,
  parameter int IDW      = 3,
  parameter int MAX_HOLD = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  rr_arbiter_8_if.slave        bus,
  output logic                 state_dbg
);

  if (NREQ != 8 || IDW != $clog2(NREQ) || MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_param_check
    $error("rr_arbiter_8: unsupported parameter set");
  end

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  state_t          state_q, state_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [IDW-1:0]  gnt_id_q, gnt_id_d;
  logic            gnt_valid_q, gnt_valid_d;
  logic [IDW-1:0]  last_q, last_d;

  // Candidates exclude the current owner; in IDLE gnt_q is zero so nothing is
  // masked, and after a release the owner's bit is already low. The owner only
  // matters when it still requests at a forced rotation, where it must lose.
  logic [NREQ-1:0] req_m;
  logic            win_any;
  logic [IDW-1:0]  win_id;
  logic [IDW-1:0]  idx;

  assign req_m = bus.req & ~gnt_q;

  // Search L-1, L-2, ..., wrapping, ending at L itself (k = NREQ wraps to L).
  always_comb begin
    win_any = 1'b0;
    win_id  = '0;
    idx     = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = last_q - IDW'(k);
      if (!win_any && req_m[idx]) begin
        win_any = 1'b1;
        win_id  = idx;
      end
    end
  end

`ifdef ARB_TIMEOUT_EN
  logic [7:0] hold_q, hold_d;
  logic       timeout_q, timeout_d;
`endif

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    gnt_id_d    = gnt_id_q;
    gnt_valid_d = gnt_valid_q;
    last_d      = last_q;
`ifdef ARB_TIMEOUT_EN
    hold_d      = hold_q;
    timeout_d   = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (bus.en && win_any) begin
          state_d     = GRANT;
          gnt_d       = NREQ'(1) << win_id;
          gnt_id_d    = win_id;
          gnt_valid_d = 1'b1;
          last_d      = win_id;
`ifdef ARB_TIMEOUT_EN
          hold_d      = 8'd1;
`endif
        end
      end
      GRANT: begin
        if (bus.req[gnt_id_q]) begin
`ifdef ARB_TIMEOUT_EN
          if (hold_q == 8'(MAX_HOLD)) begin
            if (bus.en && win_any) begin
              gnt_d     = NREQ'(1) << win_id;
              gnt_id_d  = win_id;
              last_d    = win_id;
              timeout_d = 1'b1;
            end
            hold_d = 8'd1;
          end else begin
            hold_d = hold_q + 8'd1;
          end
`endif
        end else if (bus.en && win_any) begin
          // Zero-bubble handover on the release edge.
          gnt_d    = NREQ'(1) << win_id;
          gnt_id_d = win_id;
          last_d   = win_id;
`ifdef ARB_TIMEOUT_EN
          hold_d   = 8'd1;
`endif
        end else begin
          // Pointer is kept so the next grant continues the rotation.
          state_d     = IDLE;
          gnt_d       = '0;
          gnt_id_d    = '0;
          gnt_valid_d = 1'b0;
`ifdef ARB_TIMEOUT_EN
          hold_d      = 8'd0;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      gnt_q       <= '0;
      gnt_id_q    <= '0;
      gnt_valid_q <= 1'b0;
      last_q      <= '0;
`ifdef ARB_TIMEOUT_EN
      hold_q      <= 8'd0;
      timeout_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      gnt_id_q    <= gnt_id_d;
      gnt_valid_q <= gnt_valid_d;
      last_q      <= last_d;
`ifdef ARB_TIMEOUT_EN
      hold_q      <= hold_d;
      timeout_q   <= timeout_d;
`endif
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.gnt_id    = gnt_id_q;
  assign bus.gnt_valid = gnt_valid_q;
`ifdef ARB_TIMEOUT_EN
  assign bus.timeout   = timeout_q;
`else
  assign bus.timeout   = 1'b0;
`endif
  assign state_dbg     = state_q;

endmodule
